// File: rtl/ram_16x8_pkg.sv
// Shared constants and types for the 16x8 RAM burst controller.
// Used by the controller, its interfaces and the RAM model.
package ram_16x8_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W:0]   cnt_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_CLEAR = 2'b10,
      OP_NOP   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_WRITE = 2'b01,
      S_CLEAR = 2'b10,
      S_READ  = 2'b11
   } state_t;

endpackage

// File: rtl/ram_16x8_ctrl_if.sv
// Front-end command/stream bundle and RAM-side strobe bundle.
// master drives requests, slave answers them.
interface ram_16x8_ctrl_if;
   import ram_16x8_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   addr_t      cmd_addr;
   addr_t      cmd_len;
   logic       wr_valid;
   logic       wr_ready;
   data_t      wr_data;
   logic       rd_valid;
   logic       rd_ready;
   data_t      rd_data;
   logic       busy;
   logic       done;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_len,
      output wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data,
      input  busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len,
      input  wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data,
      output busy, done
   );

endinterface

interface ram_16x8_mem_if;
   import ram_16x8_pkg::*;

   logic  we;
   logic  re;
   addr_t addr;
   data_t din;
   data_t dout;

   modport master (
      output we, re, addr, din,
      input  dout
   );

   modport slave (
      input  we, re, addr, din,
      output dout
   );

endinterface

// File: rtl/ram_16x8.sv
// Single-port 16x8 RAM with registered read data.
// dout holds its value whenever re is low; rst clears all words.
module ram_16x8
   import ram_16x8_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_we,
   input  logic  i_re,
   input  addr_t i_addr,
   input  data_t i_din,
   output data_t o_dout
);

   data_t r_mem [DEPTH];
   data_t r_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_dout <= '0;
      end else begin
         if (i_we) begin
            r_mem[i_addr] <= i_din;
         end
         if (i_re) begin
            r_dout <= r_mem[i_addr];
         end
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/ram_16x8_ctrl.sv
// Burst initiator for the 16x8 RAM: write, read and clear bursts
// of 1..16 beats with wrapping addresses and read backpressure.
module ram_16x8_ctrl
   import ram_16x8_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   ram_16x8_ctrl_if.slave bus,
   ram_16x8_mem_if.master mem
);

   state_t r_state;
   addr_t  r_cur_addr;
   addr_t  r_remain;
   cnt_t   r_iss_cnt;
   logic   r_rd_valid;
   logic   r_done;

   logic   w_idle;
   logic   w_iss_left;
   logic   w_re;
   logic   w_we;
   logic   w_wr_hs;
   logic   w_rd_hs;
   logic   w_last;

   assign w_idle     = (r_state == S_IDLE);
   assign w_iss_left = (r_iss_cnt != '0);
   assign w_last     = (r_remain == '0);
   assign w_rd_hs    = r_rd_valid && bus.rd_ready;
   assign w_wr_hs    = (r_state == S_WRITE) && bus.wr_valid;
   assign w_we       = w_wr_hs || (r_state == S_CLEAR);

   // Issue only when the output slot is free or drains this cycle.
   assign w_re = (r_state == S_READ) && w_iss_left &&
                 (!r_rd_valid || bus.rd_ready);

   assign bus.cmd_ready = w_idle;
   assign bus.wr_ready  = (r_state == S_WRITE);
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = mem.dout;
   assign bus.busy      = !w_idle;
   assign bus.done      = r_done;

   assign mem.we   = w_we;
   assign mem.re   = w_re;
   assign mem.addr = r_cur_addr;
   assign mem.din  = (r_state == S_WRITE) ? bus.wr_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cur_addr <= '0;
         r_remain   <= '0;
         r_iss_cnt  <= '0;
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_cur_addr <= bus.cmd_addr;
                  r_remain   <= bus.cmd_len;
                  unique case (op_t'(bus.cmd_op))
                     OP_READ: begin
                        r_state    <= S_READ;
                        r_iss_cnt  <= {1'b0, bus.cmd_len} + cnt_t'(1);
                        r_rd_valid <= 1'b0;
                     end
                     OP_WRITE: r_state <= S_WRITE;
                     OP_CLEAR: r_state <= S_CLEAR;
                     OP_NOP:   r_done  <= 1'b1;
                  endcase
               end
            end
            S_WRITE: begin
               if (w_wr_hs) begin
                  r_cur_addr <= r_cur_addr + addr_t'(1);
                  r_remain   <= r_remain - addr_t'(1);
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               r_cur_addr <= r_cur_addr + addr_t'(1);
               r_remain   <= r_remain - addr_t'(1);
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            S_READ: begin
               if (w_re) begin
                  r_cur_addr <= r_cur_addr + addr_t'(1);
                  r_iss_cnt  <= r_iss_cnt - cnt_t'(1);
               end
               r_rd_valid <= w_re || (r_rd_valid && !bus.rd_ready);
               if (w_rd_hs) begin
                  r_remain <= r_remain - addr_t'(1);
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
